// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared rotate-engine types and constants
package rot_pkg;

    localparam int ROT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } rot_state_t;

endpackage

// File: rtl/left_rotational_shift_engine_if.sv
// rtl/left_rotational_shift_engine_if.sv - load/result handshake bundle for the left rotate engine
import rot_pkg::*;

interface left_rotational_shift_engine_if #(
    parameter int WIDTH = ROT_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] amount;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;

    modport master (
        output load, data_in, amount, ready,
        input  data_out, valid, busy
    );

    modport slave (
        input  load, data_in, amount, ready,
        output data_out, valid, busy
    );
endinterface

// File: rtl/left_rotational_shift_engine_rotl_step.sv
// rtl/left_rotational_shift_engine_rotl_step.sv - single-position combinational left rotate
import rot_pkg::*;

module rotl_step #(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] rotated
);
    // MSB wraps around into the LSB
    assign rotated = {word[WIDTH-2:0], word[WIDTH-1]};
endmodule

// File: rtl/left_rotational_shift_engine.sv
// rtl/left_rotational_shift_engine.sv - left rotate by a programmable amount, one bit per clock
import rot_pkg::*;

module left_rotational_shift_engine #(
    parameter int WIDTH = ROT_WIDTH
) (
    input logic                          clk,
    input logic                          rst,
    left_rotational_shift_engine_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    rot_state_t       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] cnt;
    logic             valid_r;
    logic             busy_r;

    rotl_step #(.WIDTH(WIDTH)) u_step (
        .word    (shift_reg),
        .rotated (shift_next)
    );

    // FSM, counter and rotate register; valid/busy are registered alongside the state
    // so they always equal (state==DONE) and (state!=IDLE) with no input-to-output path
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shift_reg <= bus.data_in;
                        cnt       <= bus.amount;
                        busy_r    <= 1'b1;
                        if (bus.amount == '0) begin
                            state   <= DONE;
                            valid_r <= 1'b1;
                        end else begin
                            state   <= ROTATE;
                        end
                    end
                end
                ROTATE: begin
                    shift_reg <= shift_next;
                    cnt       <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // load is deliberately ignored here, even when ready completes the transfer
                    if (bus.ready) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = shift_reg;
    assign bus.valid    = valid_r;
    assign bus.busy     = busy_r;
endmodule
